t_flip_flop: RTL and testbench
==============================

T_FLIP_FLOP -- requirements
Module: t_flip_flop

Interface
REQ-001 Parameter: WIDTH, default 1, number of independent toggle bits; all vector ports are WIDTH bits wide.
REQ-002 Parameter: CLEAR_VALUE, default all-zeros, value loaded into q on clear.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge only.
REQ-004 Port: clear  input  1  reset, synchronous and active-high; sampled on the rising clk edge.
REQ-005 Port: t  input  WIDTH  per-bit toggle enable.
REQ-006 Port: q  output  WIDTH  registered flip-flop state.
REQ-007 Port: q_bar  output  WIDTH  bitwise complement of q.
REQ-008 Positional port order SHALL be q, q_bar, clk, clear, t, so that existing positional instantiations bind correctly.

Function
REQ-009 On a rising clk edge with clear=1, q SHALL load CLEAR_VALUE regardless of t.
REQ-010 On a rising clk edge with clear=0, each bit q[i] SHALL invert when t[i]=1 and hold when t[i]=0.
REQ-011 q SHALL change only on a rising clk edge; changes on t or clear between edges SHALL NOT affect q.
REQ-012 q_bar SHALL equal ~q at all times, including after clear, with no added cycle of latency.
REQ-013 Toggle latency SHALL be one edge: q reflects the edge's t/clear sample immediately after that edge.
REQ-014 Clear SHALL take priority over t when both are asserted at the same edge.
REQ-015 Bits SHALL be independent; toggling bit i SHALL NOT disturb any other bit.
REQ-016 The block SHALL contain no combinational path from t or clear to q or q_bar.

Reset
REQ-017 Before the first clear edge, q SHALL be treated as unknown; benches SHALL NOT check q until one edge with clear=1 has occurred.
REQ-018 After one clear edge, q SHALL equal CLEAR_VALUE (0 by default) and q_bar SHALL equal its complement (1 by default).
REQ-019 Asserting clear mid-toggle sequence SHALL force q to CLEAR_VALUE at that edge; toggling SHALL resume from CLEAR_VALUE at the first edge after clear is deasserted.
REQ-020 Holding clear high for multiple edges SHALL keep q at CLEAR_VALUE.

Verification
REQ-021 Scenario: clear=1, t=1, one rising edge -> q=0, q_bar=1.
REQ-022 Scenario: from q=0, clear=0, t=1, three successive edges -> q=1, 0, 1 and q_bar=0, 1, 0.
REQ-023 Scenario: from q=1, t=0 for four edges -> q stays 1 and q_bar stays 0.
REQ-024 Scenario: q=1, clear=1 and t=1 at the same edge -> q=0, q_bar=1 (clear wins).
REQ-025 Scenario: t and clear pulsed high and low between rising edges -> no change on q or q_bar until the next edge.
REQ-026 Scenario: WIDTH=4, q=0000, t=0101, two edges -> q=0101, then 0000; q_bar is the complement each cycle.

Source files
------------

// File: rtl/t_flip_flop.sv
// WIDTH independent toggle flip-flops with synchronous active-high clear to CLEAR_VALUE.
// One-edge latency from t/clear to q; q_bar is ~q with no extra cycle; no backpressure.
module t_flip_flop #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] t
);

    // Clear has priority over toggle; XOR flips only the bits whose t is set.
    always_ff @(posedge clk) begin
        if (clear) begin
            q <= CLEAR_VALUE;
        end else begin
            q <= q ^ t;
        end
    end

    assign q_bar = ~q;

endmodule

// File: tb/tb_t_flip_flop.sv
// Directed bench for t_flip_flop at WIDTH=1, WIDTH=4, and WIDTH=4 with a non-zero clear value.
module tb_t_flip_flop;

    logic       clk = 1'b0;
    logic       clear1 = 1'b0;
    logic       t1 = 1'b0;
    logic       q1, qb1;
    logic       clear4 = 1'b0;
    logic [3:0] t4 = 4'b0000;
    logic [3:0] q4, qb4, q4c, qb4c;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    t_flip_flop #(.WIDTH(1)) dut1 (
        .q(q1), .q_bar(qb1), .clk(clk), .clear(clear1), .t(t1)
    );

    t_flip_flop #(.WIDTH(4)) dut4 (
        .q(q4), .q_bar(qb4), .clk(clk), .clear(clear4), .t(t4)
    );

    t_flip_flop #(.WIDTH(4), .CLEAR_VALUE(4'b1010)) dut4c (
        .q(q4c), .q_bar(qb4c), .clk(clk), .clear(clear4), .t(t4)
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b want=%b", tag, got, exp);
        end
    endtask

    // Apply inputs, take one rising edge, sample 1 time unit after it.
    task automatic step1(input logic clr, input logic tv, input logic exp_q, input string tag);
        clear1 = clr;
        t1     = tv;
        @(posedge clk);
        #1;
        check({tag, ".q"},     {3'b000, q1},  {3'b000, exp_q});
        check({tag, ".q_bar"}, {3'b000, qb1}, {3'b000, ~exp_q});
    endtask

    task automatic step4(input logic clr, input logic [3:0] tv, input logic [3:0] exp_q,
                         input logic [3:0] exp_qc, input string tag);
        clear4 = clr;
        t4     = tv;
        @(posedge clk);
        #1;
        check({tag, ".q4"},     q4,   exp_q);
        check({tag, ".q4_bar"}, qb4,  ~exp_q);
        check({tag, ".q4c"},    q4c,  exp_qc);
        check({tag, ".q4c_bar"}, qb4c, ~exp_qc);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);

        step1(1'b1, 1'b1, 1'b0, "clear_with_t");
        step1(1'b0, 1'b1, 1'b1, "toggle1");
        step1(1'b0, 1'b1, 1'b0, "toggle2");
        step1(1'b0, 1'b1, 1'b1, "toggle3");
        for (int i = 0; i < 4; i++) step1(1'b0, 1'b0, 1'b1, "hold");
        step1(1'b1, 1'b1, 1'b0, "clear_wins");
        step1(1'b0, 1'b1, 1'b1, "resume");

        // Pulses between edges must not reach q.
        clear1 = 1'b0;
        t1     = 1'b0;
        #1;
        t1 = 1'b1;
        clear1 = 1'b1;
        #2;
        check("midcycle_high.q",     {3'b000, q1},  4'b0001);
        check("midcycle_high.q_bar", {3'b000, qb1}, 4'b0000);
        t1 = 1'b0;
        clear1 = 1'b0;
        #2;
        check("midcycle_low.q",      {3'b000, q1},  4'b0001);
        step1(1'b0, 1'b0, 1'b1, "after_pulse");

        for (int i = 0; i < 3; i++) step1(1'b1, 1'b1, 1'b0, "clear_held");
        step1(1'b0, 1'b1, 1'b1, "resume_after_held");
        step1(1'b0, 1'b0, 1'b1, "hold_after_resume");

        step4(1'b1, 4'b1111, 4'b0000, 4'b1010, "w4_clear");
        step4(1'b0, 4'b0101, 4'b0101, 4'b1111, "w4_t0101_a");
        step4(1'b0, 4'b0101, 4'b0000, 4'b1010, "w4_t0101_b");
        step4(1'b0, 4'b1000, 4'b1000, 4'b0010, "w4_msb_only");
        step4(1'b0, 4'b0001, 4'b1001, 4'b0011, "w4_lsb_only");
        step4(1'b0, 4'b0000, 4'b1001, 4'b0011, "w4_hold");
        step4(1'b1, 4'b1111, 4'b0000, 4'b1010, "w4_clear_mid");
        step4(1'b1, 4'b0110, 4'b0000, 4'b1010, "w4_clear_held");
        step4(1'b0, 4'b0011, 4'b0011, 4'b1001, "w4_resume");
        step4(1'b0, 4'b1111, 4'b1100, 4'b0110, "w4_all_toggle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
